// File: rtl/serial_uart_bridge_if.sv
// -----------------------------------------------------------------------------
// serial_uart_bridge_if
// Processor-side byte bus of the UART bridge.
//   serial_out      : byte from the processor to be transmitted
//   serial_wren_out : write strobe for serial_out
//   serial_rden_out : read strobe, pops the received byte
//   serial_in       : received byte presented to the processor (8'h00 when empty)
//   serial_valid_in : serial_in holds a valid byte
//   serial_ready_in : TX FIFO can accept a byte
// The master modport is the processor side; the slave modport is the bridge.
// -----------------------------------------------------------------------------
interface serial_uart_bridge_if;
  logic [7:0] serial_out;
  logic       serial_wren_out;
  logic       serial_rden_out;
  logic [7:0] serial_in;
  logic       serial_valid_in;
  logic       serial_ready_in;

  modport master (
    output serial_out, serial_wren_out, serial_rden_out,
    input  serial_in, serial_valid_in, serial_ready_in
  );

  modport slave (
    input  serial_out, serial_wren_out, serial_rden_out,
    output serial_in, serial_valid_in, serial_ready_in
  );
endinterface

// File: rtl/serial_uart_bridge.sv
// -----------------------------------------------------------------------------
// serial_uart_bridge
// Byte-wide processor bus to 8N1 UART bridge with a TX FIFO and an RX FIFO.
// Ports:
//   clock    : single clock, all state changes on the rising edge
//   reset    : asynchronous, active-high reset
//   bus      : processor byte bus (serial_uart_bridge_if, slave side)
//   uart_rx  : asynchronous serial line in, idle high
//   uart_tx  : registered serial line out, idle high
//   rx_error : sticky framing-error / overrun flag, cleared only by reset
// Parameters:
//   CLKS_PER_BIT : clocks per UART bit (even, >= 4)
//   FIFO_DEPTH   : entries per FIFO (power of two, >= 2)
// -----------------------------------------------------------------------------
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_uart_bridge_if.slave  bus,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic                 rx_error
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TICK_W = $clog2(CLKS_PER_BIT);

  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_TICK  = TICK_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // ---------------------------------------------------------------- TX side
  logic [7:0]        txMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  txWrPtr, txRdPtr;
  logic [CNT_W-1:0]  txCount;
  logic [1:0]        txState;
  logic [TICK_W-1:0] txTick;
  logic [2:0]        txBitIdx;
  logic [7:0]        txShift;
  logic              txPush, txPop;

  assign bus.serial_ready_in = (txCount != FULL_COUNT);
  assign txPush = bus.serial_wren_out & bus.serial_ready_in;
  // The FSM takes the next byte the moment it is idle and something is queued.
  assign txPop  = (txState == ST_IDLE) & (txCount != CNT_ZERO);

  // TX FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clock) begin
    if (txPush) txMem[txWrPtr] <= bus.serial_out;
  end

  // TX FIFO pointers and occupancy; a push and pop on one edge cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txWrPtr <= {PTR_W{1'b0}};
      txRdPtr <= {PTR_W{1'b0}};
      txCount <= CNT_ZERO;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + PTR_ONE;
      if (txPop)  txRdPtr <= txRdPtr + PTR_ONE;
      case ({txPush, txPop})
        2'b10:   txCount <= txCount + CNT_ONE;
        2'b01:   txCount <= txCount - CNT_ONE;
        default: txCount <= txCount;
      endcase
    end
  end

  // TX frame FSM; uart_tx is driven from the state register itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txState  <= ST_IDLE;
      txTick   <= {TICK_W{1'b0}};
      txBitIdx <= 3'd0;
      txShift  <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      case (txState)
        ST_IDLE: begin
          txTick <= {TICK_W{1'b0}};
          if (txPop) begin
            txShift <= txMem[txRdPtr];
            uart_tx <= 1'b0;
            txState <= ST_START;
          end else begin
            uart_tx <= 1'b1;
          end
        end
        ST_START: begin
          if (txTick == LAST_TICK) begin
            txTick   <= {TICK_W{1'b0}};
            txBitIdx <= 3'd0;
            uart_tx  <= txShift[0];
            txState  <= ST_DATA;
          end else begin
            txTick <= txTick + TICK_ONE;
          end
        end
        ST_DATA: begin
          if (txTick == LAST_TICK) begin
            txTick <= {TICK_W{1'b0}};
            if (txBitIdx == 3'd7) begin
              uart_tx <= 1'b1;
              txState <= ST_STOP;
            end else begin
              // bit 0 is already on the line, so the next bit is shift[1]
              txBitIdx <= txBitIdx + 3'd1;
              uart_tx  <= txShift[1];
              txShift  <= {1'b0, txShift[7:1]};
            end
          end else begin
            txTick <= txTick + TICK_ONE;
          end
        end
        ST_STOP: begin
          if (txTick == LAST_TICK) begin
            txTick  <= {TICK_W{1'b0}};
            txState <= ST_IDLE;
          end else begin
            txTick <= txTick + TICK_ONE;
          end
        end
        default: begin
          txState <= ST_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX side
  logic              rxSync1, rxSync2, rxLast;
  logic [1:0]        rxState;
  logic [TICK_W-1:0] rxTick;
  logic [2:0]        rxBitIdx;
  logic [7:0]        rxShift;
  logic [7:0]        rxMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rxWrPtr, rxRdPtr;
  logic [CNT_W-1:0]  rxCount;
  logic              rxStopSample, rxPushReq, rxFrameErr;
  logic              rxValid, rxPop, rxFull, rxAccept, rxOverrun;

  // Stop bit is sampled on the last tick of STOP; its level decides push vs error.
  assign rxStopSample = (rxState == ST_STOP) & (rxTick == LAST_TICK);
  assign rxPushReq    = rxStopSample & rxSync2;
  assign rxFrameErr   = rxStopSample & ~rxSync2;

  assign rxValid   = (rxCount != CNT_ZERO);
  assign rxFull    = (rxCount == FULL_COUNT);
  assign rxPop     = bus.serial_rden_out & rxValid;
  // A full FIFO still takes the byte when the processor pops on the same edge.
  assign rxAccept  = rxPushReq & (~rxFull | rxPop);
  assign rxOverrun = rxPushReq & rxFull & ~rxPop;

  assign bus.serial_valid_in = rxValid;
  assign bus.serial_in       = rxValid ? rxMem[rxRdPtr] : 8'h00;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxLast  <= 1'b1;
    end else begin
      rxSync1 <= uart_rx;
      rxSync2 <= rxSync1;
      rxLast  <= rxSync2;
    end
  end

  // RX frame FSM; START checks mid-bit so a short low glitch is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxState  <= ST_IDLE;
      rxTick   <= {TICK_W{1'b0}};
      rxBitIdx <= 3'd0;
      rxShift  <= 8'h00;
    end else begin
      case (rxState)
        ST_IDLE: begin
          rxTick <= {TICK_W{1'b0}};
          if (rxLast & ~rxSync2) rxState <= ST_START;
        end
        ST_START: begin
          if (rxTick == HALF_TICK) begin
            rxTick   <= {TICK_W{1'b0}};
            rxBitIdx <= 3'd0;
            rxState  <= rxSync2 ? ST_IDLE : ST_DATA;
          end else begin
            rxTick <= rxTick + TICK_ONE;
          end
        end
        ST_DATA: begin
          if (rxTick == LAST_TICK) begin
            rxTick  <= {TICK_W{1'b0}};
            rxShift <= {rxSync2, rxShift[7:1]};
            if (rxBitIdx == 3'd7) begin
              rxState <= ST_STOP;
            end else begin
              rxBitIdx <= rxBitIdx + 3'd1;
            end
          end else begin
            rxTick <= rxTick + TICK_ONE;
          end
        end
        ST_STOP: begin
          if (rxTick == LAST_TICK) begin
            rxTick  <= {TICK_W{1'b0}};
            rxState <= ST_IDLE;
          end else begin
            rxTick <= rxTick + TICK_ONE;
          end
        end
        default: rxState <= ST_IDLE;
      endcase
    end
  end

  // RX FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clock) begin
    if (rxAccept) rxMem[rxWrPtr] <= rxShift;
  end

  // RX FIFO pointers, occupancy and the sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxWrPtr  <= {PTR_W{1'b0}};
      rxRdPtr  <= {PTR_W{1'b0}};
      rxCount  <= CNT_ZERO;
      rx_error <= 1'b0;
    end else begin
      if (rxAccept) rxWrPtr <= rxWrPtr + PTR_ONE;
      if (rxPop)    rxRdPtr <= rxRdPtr + PTR_ONE;
      case ({rxAccept, rxPop})
        2'b10:   rxCount <= rxCount + CNT_ONE;
        2'b01:   rxCount <= rxCount - CNT_ONE;
        default: rxCount <= rxCount;
      endcase
      if (rxFrameErr | rxOverrun) rx_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// -----------------------------------------------------------------------------
// tb_serial_uart_bridge
// Self-checking bench for serial_uart_bridge (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Bytes written to the TX FIFO are queued in txExp and checked by a frame
// decoder on uart_tx; bytes driven onto uart_rx that should be stored are
// queued in rxExp and checked when the processor side reads them.
// -----------------------------------------------------------------------------
module tb_serial_uart_bridge;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;
  logic uart_rx;
  logic uart_tx;
  logic rx_error;

  serial_uart_bridge_if bus();

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_error (rx_error)
  );

  always #5 clock = ~clock;

  int         checks  = 0;
  int         errors  = 0;
  logic [7:0] txExp[$];
  logic [7:0] rxExp[$];
  bit         txAbort = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one write cycle; the bench decides from expReady whether it lands.
  task automatic writeSeq(input logic [7:0] b, input bit expReady);
    bus.serial_out      = b;
    bus.serial_wren_out = 1'b1;
    checkVal("txReady", 32'(bus.serial_ready_in), 32'(expReady));
    if (expReady) txExp.push_back(b);
    tick();
  endtask

  // Drive one 8N1 frame on uart_rx followed by a short idle gap.
  task automatic sendRx(input logic [7:0] b, input bit stopBit, input bit expectPush);
    if (expectPush) rxExp.push_back(b);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    uart_rx = stopBit;
    repeat (CPB) tick();
    uart_rx = 1'b1;
    repeat (6) tick();
  endtask

  // Read one byte from the RX FIFO and compare it with the scoreboard.
  task automatic readRx();
    logic [7:0] e;
    checkVal("rxValid", 32'(bus.serial_valid_in), 32'd1);
    checkVal("rxQueueNonEmpty", 32'(rxExp.size() != 0), 32'd1);
    if (rxExp.size() != 0) begin
      e = rxExp.pop_front();
      checkVal("rxData", 32'(bus.serial_in), 32'(e));
    end
    bus.serial_rden_out = 1'b1;
    tick();
    bus.serial_rden_out = 1'b0;
  endtask

  task automatic waitTxDrain(input int budget);
    int n = 0;
    while (txExp.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkVal("txDrain", 32'(txExp.size()), 32'd0);
  endtask

  // Frame decoder on uart_tx: samples each bit near its middle.
  initial begin : txMonitor
    logic [7:0] b;
    logic [7:0] e;
    b = 8'h00;
    forever begin
      @(posedge clock);
      #2;
      if (reset === 1'b0 && uart_tx === 1'b0) begin
        repeat (2) begin @(posedge clock); #2; end
        if (!txAbort) checkVal("txStartBit", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(posedge clock); #2; end
          b[i] = uart_tx;
        end
        repeat (CPB) begin @(posedge clock); #2; end
        if (!txAbort) begin
          checkVal("txStopBit", 32'(uart_tx), 32'd1);
          checkVal("txQueueNonEmpty", 32'(txExp.size() != 0), 32'd1);
          if (txExp.size() != 0) begin
            e = txExp.pop_front();
            checkVal("txByte", 32'(b), 32'(e));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    logic [9:0] frame;
    logic [7:0] six [6];
    int lows;
    six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    reset               = 1'b1;
    uart_rx             = 1'b1;
    bus.serial_out      = 8'h00;
    bus.serial_wren_out = 1'b0;
    bus.serial_rden_out = 1'b0;
    repeat (2) tick();

    // Reset state
    checkVal("rstTx",     32'(uart_tx),             32'd1);
    checkVal("rstReady",  32'(bus.serial_ready_in), 32'd1);
    checkVal("rstValid",  32'(bus.serial_valid_in), 32'd0);
    checkVal("rstRxData", 32'(bus.serial_in),       32'd0);
    checkVal("rstRxErr",  32'(rx_error),            32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Single byte A5: exact waveform cycle by cycle
    writeSeq(8'hA5, 1'b1);
    bus.serial_wren_out = 1'b0;
    checkVal("a5PreIdle", 32'(uart_tx), 32'd1);
    tick();
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      checkVal("a5Bit", 32'(uart_tx), 32'(frame[c / CPB]));
      tick();
    end
    checkVal("a5After", 32'(uart_tx), 32'd1);
    waitTxDrain(50);
    repeat (5) tick();

    // Six back-to-back writes: five fit (one drains straight into the FSM)
    for (int k = 0; k < 6; k++) writeSeq(six[k], k < 5);
    bus.serial_wren_out = 1'b0;
    checkVal("readyAfterFill", 32'(bus.serial_ready_in), 32'd0);
    waitTxDrain(5 * 10 * CPB + 60);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      if (uart_tx !== 1'b1) lows++;
      tick();
    end
    checkVal("txQuietAfterFive", 32'(lows), 32'd0);

    // Valid RX frame, then pop it
    sendRx(8'h3C, 1'b1, 1'b1);
    readRx();
    checkVal("rxValidAfterPop", 32'(bus.serial_valid_in), 32'd0);
    checkVal("rxDataAfterPop",  32'(bus.serial_in),       32'd0);
    checkVal("rxErrClean",      32'(rx_error),            32'd0);
    bus.serial_rden_out = 1'b1;
    tick();
    bus.serial_rden_out = 1'b0;
    checkVal("rdenEmptyIgnored", 32'(bus.serial_valid_in), 32'd0);

    // Framing error: stop bit low
    sendRx(8'h5A, 1'b0, 1'b0);
    checkVal("frameErrNoPush", 32'(bus.serial_valid_in), 32'd0);
    checkVal("frameErrFlag",   32'(rx_error),            32'd1);
    repeat (20) tick();
    checkVal("frameErrSticky", 32'(rx_error), 32'd1);
    reset = 1'b1;
    tick();
    checkVal("frameErrCleared", 32'(rx_error), 32'd0);
    reset = 1'b0;
    tick();

    // One-cycle glitch, then overflow with five frames
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (10) tick();
    checkVal("glitchNoByte", 32'(bus.serial_valid_in), 32'd0);
    checkVal("glitchNoErr",  32'(rx_error),            32'd0);
    for (int k = 0; k < 5; k++) sendRx(8'hC1 + 8'(k * 17), 1'b1, k < 4);
    checkVal("overrunFlag", 32'(rx_error), 32'd1);
    repeat (4) readRx();
    checkVal("overrunEmpty", 32'(bus.serial_valid_in), 32'd0);
    checkVal("rxScoreboardEmpty", 32'(rxExp.size()), 32'd0);

    // Reset mid-DATA with two bytes queued
    writeSeq(8'h81, 1'b1);
    writeSeq(8'h42, 1'b1);
    writeSeq(8'h24, 1'b1);
    bus.serial_wren_out = 1'b0;
    repeat (12) tick();
    checkVal("midFrameLow", 32'(uart_tx), 32'd0);
    txAbort = 1'b1;
    reset   = 1'b1;
    #1;
    checkVal("abortTxHigh", 32'(uart_tx),             32'd1);
    checkVal("abortReady",  32'(bus.serial_ready_in), 32'd1);
    checkVal("abortValid",  32'(bus.serial_valid_in), 32'd0);
    txExp.delete();
    repeat (3) tick();
    reset = 1'b0;
    lows = 0;
    for (int c = 0; c < 100; c++) begin
      if (uart_tx !== 1'b1) lows++;
      tick();
    end
    checkVal("abortNoTraffic", 32'(lows), 32'd0);
    checkVal("abortReadyAfter", 32'(bus.serial_ready_in), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
